velocity_cell_updater: RTL and testbench

Per-cell sequencer that drives the master side of one cell's single-port velocity RAM. On `start` it reads the particle count from address 0, then, for each particle, reads the stored `{vz, vy, vx}` word and presents it to the motion-update datapath. It accepts the updated velocity back and writes it to the same address. It sits between the cell's velocity RAM and the motion-update unit, one instance per cell.

---
 rtl/md_vel_pkg.sv | 26 ++
 rtl/velocity_cell_updater_latency_counter.sv | 41 ++++
 rtl/velocity_cell_updater.sv | 198 +++++++++++++++++++
 tb/tb_velocity_cell_updater.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_vel_pkg.sv
// Shared types and constants for the per-cell velocity update sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_vel_pkg;

    // One 32-bit lane per velocity component.
    localparam int VEL_LANE_W = 32;

    // LSB positions of each lane in a {vz, vy, vx} word.
    // Use as word[VX +: VEL_LANE_W].
    localparam int VX = 0;
    localparam int VY = VEL_LANE_W;
    localparam int VZ = 2 * VEL_LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        RD_VEL,
        WAIT_VEL,
        PRESENT,
        WAIT_UPD,
        WR
    } vel_upd_state_t;

endpackage

// File: rtl/velocity_cell_updater_latency_counter.sv
// Down-counter that marks the last cycle of a fixed RAM read latency.
// Latency: expire is high LATENCY cycles after the load cycle, for one cycle.
// Backpressure: none; load restarts the count, en advances it.
// Ports: clk/rst, load (preset to LATENCY), en (decrement), expire (count is 1).
module latency_counter #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = 3;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(LATENCY);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // The wait state sees cnt_q == LATENCY on its first cycle, so reaching 1
    // marks exactly the cycle in which the RAM data is valid.
    assign expire = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/velocity_cell_updater.sv
// Per-cell sequencer: reads the count word, then read/present/update/write per particle.
// Latency: RAM_LATENCY+4 cycles per particle with zero-wait handshakes; done one cycle after the last write.
// Backpressure: holds vel_out while vel_out_ready is low; waits indefinitely for vel_in_valid.
// Ports: start/busy/done control; ram_* master port of the cell velocity RAM;
//        vel_out_* old velocity to the update unit; vel_in_* updated velocity back.
module velocity_cell_updater #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  vel_out_valid,
    input  logic                  vel_out_ready,
    output logic [DATA_WIDTH-1:0] vel_out,
    output logic [ADDR_WIDTH-1:0] vel_out_id,
    input  logic                  vel_in_valid,
    input  logic [DATA_WIDTH-1:0] vel_in
);

    import md_vel_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    vel_upd_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rden_q, rden_d;
    logic                  wren_q, wren_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] vout_q, vout_d;
    logic [ADDR_WIDTH-1:0] vid_q, vid_d;

    logic                  lat_load;
    logic                  lat_en;
    logic                  lat_expire;
    logic [ADDR_WIDTH-1:0] cnt_sat;

    latency_counter #(
        .LATENCY (RAM_LATENCY)
    ) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load   (lat_load),
        .en     (lat_en),
        .expire (lat_expire)
    );

    // Count word saturates so idx can never run past the RAM depth.
    assign cnt_sat = (ram_q[ADDR_WIDTH-1:0] > CNT_MAX) ? CNT_MAX : ram_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rden_d   = 1'b0;
        wren_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        vld_d    = vld_q;
        vout_d   = vout_q;
        vid_d    = vid_q;
        lat_load = 1'b0;
        lat_en   = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE with busy still high; start
                // is only taken once done has dropped.
                busy_d = 1'b0;
                if (start && !done_q) begin
                    state_d = RD_CNT;
                    busy_d  = 1'b1;
                    rden_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            RD_CNT: begin
                state_d  = WAIT_CNT;
                lat_load = 1'b1;
            end
            WAIT_CNT: begin
                lat_en = 1'b1;
                if (lat_expire) begin
                    count_d = cnt_sat;
                    if (cnt_sat == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = ADDR_WIDTH'(1);
                        addr_d  = ADDR_WIDTH'(1);
                        rden_d  = 1'b1;
                        state_d = RD_VEL;
                    end
                end
            end
            RD_VEL: begin
                state_d  = WAIT_VEL;
                lat_load = 1'b1;
            end
            WAIT_VEL: begin
                lat_en = 1'b1;
                if (lat_expire) begin
                    vout_d  = ram_q;
                    vid_d   = idx_q;
                    vld_d   = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (vel_out_ready) begin
                    vld_d   = 1'b0;
                    state_d = WAIT_UPD;
                end
            end
            WAIT_UPD: begin
                if (vel_in_valid) begin
                    data_d  = vel_in;
                    addr_d  = idx_q;
                    wren_d  = 1'b1;
                    state_d = WR;
                end
            end
            WR: begin
                if (idx_q == count_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    addr_d  = idx_q + ADDR_WIDTH'(1);
                    rden_d  = 1'b1;
                    state_d = RD_VEL;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            vout_q  <= '0;
            vid_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            vout_q  <= vout_d;
            vid_q   <= vid_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_address   = addr_q;
    assign ram_data      = data_q;
    assign ram_rden      = rden_q;
    assign ram_wren      = wren_q;
    assign vel_out_valid = vld_q;
    assign vel_out       = vout_q;
    assign vel_out_id    = vid_q;

endmodule

// File: tb/tb_velocity_cell_updater.sv
// Directed bench for velocity_cell_updater with a behavioural latency-L RAM.
// Latency: n/a.
// Backpressure: driven per scenario (tied-high or scripted handshakes).
module tb_velocity_cell_updater;

    import md_vel_pkg::*;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_rden, ram_wren;
    logic [DW-1:0] ram_q;
    logic          vel_out_valid;
    logic          vel_out_ready;
    logic [DW-1:0] vel_out;
    logic [AW-1:0] vel_out_id;
    logic          vel_in_valid;
    logic [DW-1:0] vel_in;

    logic          inc_mode = 1'b1;
    logic          rdy_drv  = 1'b0;
    logic          ivld_drv = 1'b0;
    logic [DW-1:0] vin_drv  = '0;
    logic          load_req = 1'b0;

    logic [DW-1:0] img  [PN];
    logic [DW-1:0] mem  [PN];
    logic [DW-1:0] pipe [L];

    logic [AW-1:0] rd_log [$];
    logic [AW-1:0] wr_log [$];
    int            overlap_cnt = 0;
    int            wr0_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] inc3(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = w;
        r[VX +: VEL_LANE_W] = w[VX +: VEL_LANE_W] + 32'd1;
        r[VY +: VEL_LANE_W] = w[VY +: VEL_LANE_W] + 32'd1;
        r[VZ +: VEL_LANE_W] = w[VZ +: VEL_LANE_W] + 32'd1;
        return r;
    endfunction

    assign vel_out_ready = inc_mode ? 1'b1 : rdy_drv;
    assign vel_in_valid  = inc_mode ? 1'b1 : ivld_drv;
    assign vel_in        = inc_mode ? inc3(vel_out) : vin_drv;
    assign ram_q         = pipe[L-1];

    velocity_cell_updater #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .RAM_LATENCY  (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_rden      (ram_rden),
        .ram_wren      (ram_wren),
        .ram_q         (ram_q),
        .vel_out_valid (vel_out_valid),
        .vel_out_ready (vel_out_ready),
        .vel_out       (vel_out),
        .vel_out_id    (vel_out_id),
        .vel_in_valid  (vel_in_valid),
        .vel_in        (vel_in)
    );

    // Behavioural RAM: read data appears L cycles after the rden cycle.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < PN; i++) mem[i] <= img[i];
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
        if (ram_rden) pipe[0] <= mem[ram_address];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rden) rd_log.push_back(ram_address);
            if (ram_wren) begin
                wr_log.push_back(ram_address);
                if (ram_address == '0) wr0_cnt++;
            end
            if (ram_rden && ram_wren) overlap_cnt++;
        end
    end

    task automatic load_image();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    // Start is high during cycle 0; returns in cycle 1.
    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // k is the cycle index (start cycle = 0) at which done is seen.
    task automatic wait_done(input int budget, output int k);
        bit found = 0;
        k = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
            k++;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
            k = -1;
        end
    endtask

    task automatic wait_valid(input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (vel_out_valid) begin found = 1; break; end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL valid_timeout: no vel_out_valid within %0d cycles", budget);
        end
    endtask

    task automatic handshake(input logic [DW-1:0] upd);
        rdy_drv = 1'b1;
        @(posedge clk); #1 rdy_drv = 1'b0;
        ivld_drv = 1'b1; vin_drv = upd;
        @(posedge clk); #1 ivld_drv = 1'b0;
    endtask

    task automatic fill(input logic [DW-1:0] cnt_word);
        img[0] = cnt_word;
        for (int i = 1; i < PN; i++)
            img[i] = {32'(i * 3 + 32'h3000_0000), 32'(i * 7 + 32'h2000_0000), 32'(i + 32'h1000_0000)};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, ram_rden, ram_wren, vel_out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, ram_rden, ram_wren, vel_out_valid});
        end
        checks++;
        if ({ram_address, ram_data, vel_out, vel_out_id} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0h data=%0h vout=%0h id=%0h want 0", ram_address, ram_data, vel_out, vel_out_id);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_count3();
        int k; int rb; int wb;
        fill(96'd3); load_image();
        inc_mode = 1'b1;
        rb = rd_log.size(); wb = wr_log.size();
        kick();
        wait_done(100, k);
        checks++;
        if (k != 22) begin errors++; $display("FAIL c3_done_cycle: got %0d want 22", k); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL c3_busy_at_done: got %b want 1", busy); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL c3_after_done: busy,done=%b want 00", {busy, done}); end
        checks++;
        if (rd_log.size() - rb != 4 || rd_log[rb] != 0 || rd_log[rb+1] != 1 || rd_log[rb+2] != 2 || rd_log[rb+3] != 3) begin
            errors++; $display("FAIL c3_reads: got %0d reads want 0,1,2,3", rd_log.size() - rb);
        end
        checks++;
        if (wr_log.size() - wb != 3 || wr_log[wb] != 1 || wr_log[wb+1] != 2 || wr_log[wb+2] != 3) begin
            errors++; $display("FAIL c3_writes: got %0d writes want 1,2,3", wr_log.size() - wb);
        end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (mem[i] !== inc3(img[i])) begin
                errors++; $display("FAIL c3_data[%0d]: got %h want %h", i, mem[i], inc3(img[i]));
            end
        end
    endtask

    task automatic test_count0();
        int k; int rb; int wb;
        fill(96'hABC_0000_0000_0000_5500);
        load_image();
        rb = rd_log.size(); wb = wr_log.size();
        kick();
        wait_done(20, k);
        checks++;
        if (k != 2 + L) begin errors++; $display("FAIL c0_done_cycle: got %0d want %0d", k, 2 + L); end
        checks++;
        if (rd_log.size() - rb != 1 || wr_log.size() != wb) begin
            errors++; $display("FAIL c0_access: reads=%0d writes=%0d want 1,0", rd_log.size() - rb, wr_log.size() - wb);
        end
    endtask

    task automatic test_saturate();
        int k; int wb;
        fill(96'hFF); load_image();
        inc_mode = 1'b1;
        wb = wr_log.size();
        kick();
        wait_done(2000, k);
        checks++;
        if (k != 1 + L + 219 * (L + 4) + 1) begin errors++; $display("FAIL sat_done_cycle: got %0d want %0d", k, 1 + L + 219 * (L + 4) + 1); end
        checks++;
        if (wr_log.size() - wb != 219) begin errors++; $display("FAIL sat_writes: got %0d want 219", wr_log.size() - wb); end
        else begin
            checks++;
            if (wr_log[wb+218] != 219) begin errors++; $display("FAIL sat_last_addr: got %0d want 219", wr_log[wb+218]); end
        end
        checks++;
        if (mem[0] !== img[0]) begin errors++; $display("FAIL sat_addr0: got %h want %h", mem[0], img[0]); end
        checks++;
        if (mem[219] !== inc3(img[219])) begin errors++; $display("FAIL sat_data219: got %h want %h", mem[219], inc3(img[219])); end
    endtask

    task automatic test_backpressure();
        int k; int wb; int unstable;
        logic [DW-1:0] so; logic [AW-1:0] sid;
        fill(96'd2); load_image();
        inc_mode = 1'b0; unstable = 0;
        wb = wr_log.size();
        kick();
        for (int p = 1; p <= 2; p++) begin
            wait_valid(20);
            so = vel_out; sid = vel_out_id;
            checks++;
            if (sid !== AW'(p) || so !== img[p]) begin
                errors++; $display("FAIL bp_present[%0d]: id=%0d word=%h want id=%0d word=%h", p, sid, so, p, img[p]);
            end
            for (int i = 0; i < 5; i++) begin
                if (!vel_out_valid || vel_out !== so || vel_out_id !== sid) unstable++;
                if (i == 2) begin ivld_drv = 1'b1; vin_drv = {DW{1'b1}}; end
                @(posedge clk); #1 ivld_drv = 1'b0;
            end
            rdy_drv = 1'b1;
            @(posedge clk); #1 rdy_drv = 1'b0;
            repeat (7) @(posedge clk);
            #1 ivld_drv = 1'b1; vin_drv = inc3(img[p]);
            @(posedge clk); #1 ivld_drv = 1'b0;
        end
        wait_done(20, k);
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", unstable); end
        checks++;
        if (wr_log.size() - wb != 2) begin errors++; $display("FAIL bp_writes: got %0d want 2", wr_log.size() - wb); end
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (mem[i] !== inc3(img[i])) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, mem[i], inc3(img[i])); end
        end
    endtask

    task automatic test_rst_mid();
        int k; int rb; int wb;
        fill(96'd3); load_image();
        inc_mode = 1'b0;
        wb = wr_log.size();
        kick();
        wait_valid(20);
        handshake(inc3(img[1]));
        wait_valid(20);
        rdy_drv = 1'b1;
        @(posedge clk); #1 rdy_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; ivld_drv = 1'b1; vin_drv = inc3(img[2]);
        #1;
        checks++;
        if ({busy, done, ram_rden, ram_wren, vel_out_valid} !== 5'b0 || {ram_address, ram_data, vel_out, vel_out_id} !== '0) begin
            errors++;
            $display("FAIL mid_rst_outputs: ctrl=%b addr=%0h data=%0h id=%0h want all 0",
                     {busy, done, ram_rden, ram_wren, vel_out_valid}, ram_address, ram_data, vel_out_id);
        end
        @(posedge clk); #1 ivld_drv = 1'b0; rst = 1'b0;
        repeat (5) @(posedge clk);
        checks++;
        if (wr_log.size() - wb != 1) begin errors++; $display("FAIL mid_rst_writes: got %0d want 1", wr_log.size() - wb); end
        load_image();
        inc_mode = 1'b1;
        rb = rd_log.size();
        kick();
        wait_done(100, k);
        checks++;
        if (k != 22 || rd_log[rb] != 0) begin
            errors++; $display("FAIL mid_rst_restart: done_cycle=%0d first_read=%0d want 22,0", k, rd_log[rb]);
        end
    endtask

    task automatic test_back_to_back();
        int n; int nd; int d1; int d2; int wb;
        fill(96'd1); load_image();
        inc_mode = 1'b1;
        wb = wr_log.size();
        nd = 0; d1 = -1; d2 = -1;
        @(posedge clk); #1 start = 1'b1;
        n = 0;
        while (nd < 2 && n < 60) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) d1 = n; else d2 = n;
                nd++;
            end
            n++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (d1 != 10 || d2 != 21) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d want 10,21", d1, d2); end
        checks++;
        if (busy !== 1'b0 || wr_log.size() - wb != 2) begin
            errors++; $display("FAIL b2b_end: busy=%b writes=%0d want 0,2", busy, wr_log.size() - wb);
        end
        checks++;
        if (mem[1] !== inc3(inc3(img[1]))) begin errors++; $display("FAIL b2b_data: got %h want %h", mem[1], inc3(inc3(img[1]))); end
    endtask

    initial begin
        test_reset();
        test_count3();
        test_count0();
        test_saturate();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL rden_wren_overlap: got %0d cycles want 0", overlap_cnt); end
        checks++;
        if (wr0_cnt != 0) begin errors++; $display("FAIL addr0_written: got %0d writes want 0", wr0_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
